bicubic_pixel_normalize: RTL and testbench

Output stage of the bicubic datapath, directly downstream of the stage-2 vector multiplier. It takes the three per-channel 32-bit inner products (R, G, B) for one output pixel, then applies rounding and a fixed-point shift, clamps each channel to 8 bits and packs a 24-bit RGB pixel. It buffers results in a small FIFO and emits them on a valid/ready stream with start-of-frame and end-of-line markers for the output writer.

---
 rtl/bicubic_pixel_normalize_if.sv | 26 ++
 rtl/bicubic_pixel_normalize.sv | 160 ++++++++++++++++
 tb/tb_bicubic_pixel_normalize.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bicubic_pixel_normalize_if.sv
// Stream bundle for the bicubic output normaliser: per-channel inner products in,
// packed RGB pixels with framing markers out.
interface bicubic_pixel_normalize_if #(
    parameter int PRODUCT_WIDTH = 32
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [PRODUCT_WIDTH-1:0] prod_r;
    logic [PRODUCT_WIDTH-1:0] prod_g;
    logic [PRODUCT_WIDTH-1:0] prod_b;
    logic                     out_valid;
    logic                     out_ready;
    logic [23:0]              out_pixel;
    logic                     out_sof;
    logic                     out_eol;

    modport master (
        output in_valid, prod_r, prod_g, prod_b, out_ready,
        input  in_ready, out_valid, out_pixel, out_sof, out_eol
    );

    modport slave (
        input  in_valid, prod_r, prod_g, prod_b, out_ready,
        output in_ready, out_valid, out_pixel, out_sof, out_eol
    );
endinterface

// File: rtl/bicubic_pixel_normalize.sv
// Rounds, shifts and clamps three signed inner products into a 24-bit RGB pixel,
// buffers it in a small FWFT FIFO and tags it with frame/line position markers.
module bicubic_pixel_normalize #(
    parameter int PRODUCT_WIDTH = 32,
    parameter int FRAC_BITS     = 16,
    parameter int LINE_WIDTH    = 3840,
    parameter int FRAME_LINES   = 2160,
    parameter int FIFO_DEPTH    = 4
) (
    input logic                      clk,
    input logic                      rst_n,
    bicubic_pixel_normalize_if.slave bus
);
    localparam int PW    = PRODUCT_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int COL_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int ROW_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

    localparam logic signed [PW:0]  ROUND_CONST  = (PW + 1)'(1) << (FRAC_BITS - 1);
    localparam logic [COL_W-1:0]    COL_LAST     = COL_W'(LINE_WIDTH - 1);
    localparam logic [ROW_W-1:0]    ROW_LAST     = ROW_W'(FRAME_LINES - 1);
    localparam logic [CNT_W:0]      CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    // One extra bit of headroom so adding the rounding constant to the most
    // positive product cannot wrap before the shift.
    function automatic logic signed [PW:0] roundShift(input logic [PW-1:0] prod);
        logic signed [PW:0] biased;
        biased = $signed({prod[PW-1], prod}) + ROUND_CONST;
        return biased >>> FRAC_BITS;
    endfunction

    function automatic logic [7:0] clampByte(input logic signed [PW:0] value);
        logic [7:0] result;
        if (value[PW]) begin
            result = 8'd0;
        end else if (|value[PW-1:8]) begin
            result = 8'hFF;
        end else begin
            result = value[7:0];
        end
        return result;
    endfunction

    logic                   inAccept;
    logic                   outAccept;
    logic                   fifoWrite;
    logic [CNT_W:0]         creditsUsed;

    logic                   stageAValid_q, stageAValid_d;
    logic signed [PW:0]     stageAR_q, stageAR_d;
    logic signed [PW:0]     stageAG_q, stageAG_d;
    logic signed [PW:0]     stageAB_q, stageAB_d;

    logic                   stageBValid_q, stageBValid_d;
    logic [23:0]            stageBPixel_q, stageBPixel_d;

    logic [23:0]            fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]       rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic [COL_W-1:0]       col_q, col_d;
    logic [ROW_W-1:0]       row_q, row_d;

    // Credits cover every pixel already in flight, so the FIFO can never overflow.
    assign creditsUsed   = {1'b0, count_q} + (CNT_W + 1)'(stageAValid_q) + (CNT_W + 1)'(stageBValid_q);
    assign bus.in_ready  = (creditsUsed < CREDIT_LIMIT);
    assign inAccept      = bus.in_valid && bus.in_ready;

    assign bus.out_valid = (count_q != '0);
    assign outAccept     = bus.out_valid && bus.out_ready;
    assign fifoWrite     = stageBValid_q;
    assign bus.out_pixel = bus.out_valid ? fifoMem_q[rdPtr_q] : 24'd0;
    assign bus.out_eol   = (col_q == COL_LAST);
    assign bus.out_sof   = (col_q == '0) && (row_q == '0);

    always_comb begin
        stageAValid_d = inAccept;
        stageAR_d     = stageAR_q;
        stageAG_d     = stageAG_q;
        stageAB_d     = stageAB_q;
        if (inAccept) begin
            stageAR_d = roundShift(bus.prod_r);
            stageAG_d = roundShift(bus.prod_g);
            stageAB_d = roundShift(bus.prod_b);
        end

        stageBValid_d = stageAValid_q;
        stageBPixel_d = stageBPixel_q;
        if (stageAValid_q) begin
            stageBPixel_d = {clampByte(stageAR_q), clampByte(stageAG_q), clampByte(stageAB_q)};
        end
    end

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (fifoWrite) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (outAccept) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({fifoWrite, outAccept})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Frame position tracks the pixel currently presented, so it moves only on a transfer.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (outAccept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stageAValid_q <= 1'b0;
            stageAR_q     <= '0;
            stageAG_q     <= '0;
            stageAB_q     <= '0;
            stageBValid_q <= 1'b0;
            stageBPixel_q <= '0;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            col_q         <= '0;
            row_q         <= '0;
        end else begin
            stageAValid_q <= stageAValid_d;
            stageAR_q     <= stageAR_d;
            stageAG_q     <= stageAG_d;
            stageAB_q     <= stageAB_d;
            stageBValid_q <= stageBValid_d;
            stageBPixel_q <= stageBPixel_d;
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            count_q       <= count_d;
            col_q         <= col_d;
            row_q         <= row_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifoWrite) begin
            fifoMem_q[wrPtr_q] <= stageBPixel_q;
        end
    end
endmodule

// File: tb/tb_bicubic_pixel_normalize.sv
// Randomised and directed checks of the pixel normaliser against an arithmetic
// model (floor-divide rounding, clamp, pixel-index framing).
module tb_bicubic_pixel_normalize;
    localparam int PW          = 32;
    localparam int FRAC_BITS   = 16;
    localparam int LINE_WIDTH  = 4;
    localparam int FRAME_LINES = 2;
    localparam int FIFO_DEPTH  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checkCount = 0;
    int passCount  = 0;

    logic [23:0] expQueue [$];
    logic [23:0] expPix;
    int          outIdx = 0;

    bicubic_pixel_normalize_if #(.PRODUCT_WIDTH(PW)) bus ();

    bicubic_pixel_normalize #(
        .PRODUCT_WIDTH (PW),
        .FRAC_BITS     (FRAC_BITS),
        .LINE_WIDTH    (LINE_WIDTH),
        .FRAME_LINES   (FRAME_LINES),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Value = product / 2^FRAC_BITS rounded half up, i.e. floor((p + half) / scale).
    function automatic logic [7:0] modelChannel(input logic [31:0] prod);
        longint scale;
        longint value;
        longint quotient;
        logic [7:0] result;
        scale    = longint'(1) << FRAC_BITS;
        value    = longint'($signed(prod)) + scale / 2;
        quotient = value / scale;
        if ((value % scale != 0) && (value < 0)) begin
            quotient = quotient - 1;
        end
        if (quotient < 0) begin
            result = 8'd0;
        end else if (quotient > 255) begin
            result = 8'd255;
        end else begin
            result = 8'(quotient);
        end
        return result;
    endfunction

    function automatic logic [23:0] modelPixel(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
        return {modelChannel(r), modelChannel(g), modelChannel(b)};
    endfunction

    function automatic logic [31:0] randProd();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0:       v = $urandom();
            1:       v = (32'($urandom_range(0, 300)) << 16) | 32'($urandom_range(0, 65535));
            2:       v = (32'($urandom_range(0, 300)) << 16) | (($urandom_range(0, 1) == 1) ? 32'h8000 : 32'h7FFF);
            3:       v = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: v = 32'd0 - 32'($urandom_range(0, 1 << 20));
        endcase
        return v;
    endfunction

    // Scoreboard: inputs accepted are queued through the model, outputs are popped in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            expQueue.delete();
            outIdx = 0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                checkOutput("queueNotEmpty", 32'(expQueue.size() != 0), 32'd1);
                if (expQueue.size() != 0) begin
                    expPix = expQueue.pop_front();
                    checkOutput("pixel", 32'(bus.out_pixel), 32'(expPix));
                    checkOutput("sof", 32'(bus.out_sof), 32'((outIdx % (LINE_WIDTH * FRAME_LINES)) == 0));
                    checkOutput("eol", 32'(bus.out_eol), 32'((outIdx % LINE_WIDTH) == LINE_WIDTH - 1));
                    outIdx++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                expQueue.push_back(modelPixel(bus.prod_r, bus.prod_g, bus.prod_b));
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic driveRandom();
        bus.prod_r = randProd();
        bus.prod_g = randProd();
        bus.prod_b = randProd();
    endtask

    task automatic applyStimulus(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
        int waited;
        waited     = 0;
        bus.prod_r = r;
        bus.prod_g = g;
        bus.prod_b = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 20) begin
            stepCycle();
            waited++;
        end
        checkOutput("acceptBound", 32'(waited < 20), 32'd1);
        stepCycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic runCycles(input int n, input int inPct, input int outPct, input bit toggle);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = ($urandom_range(0, 99) < inPct);
            if (toggle) begin
                bus.out_ready = ~bus.out_ready;
            end else begin
                bus.out_ready = ($urandom_range(0, 99) < outPct);
            end
            driveRandom();
            stepCycle();
        end
    endtask

    task automatic drain();
        int waited;
        waited        = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while ((expQueue.size() != 0 || bus.out_valid) && waited < 50) begin
            stepCycle();
            waited++;
        end
        checkOutput("drainBound", 32'(waited < 50), 32'd1);
        checkOutput("drainEmpty", 32'(expQueue.size()), 32'd0);
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        stepCycle();
        rst_n = 1'b1;
        stepCycle();
    endtask

    initial begin
        int accepted;
        int waited;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.prod_r    = '0;
        bus.prod_g    = '0;
        bus.prod_b    = '0;
        repeat (3) @(posedge clk);
        #1;

        checkOutput("rstInReady",  32'(bus.in_ready),  32'd1);
        checkOutput("rstOutValid", 32'(bus.out_valid), 32'd0);
        checkOutput("rstOutPixel", 32'(bus.out_pixel), 32'd0);
        checkOutput("rstOutSof",   32'(bus.out_sof),   32'd1);
        checkOutput("rstOutEol",   32'(bus.out_eol),   32'd0);
        rst_n = 1'b1;
        stepCycle();

        // Rounding: exactly-half rounds up, just-below-half rounds down; two-edge latency.
        bus.out_ready = 1'b1;
        applyStimulus(32'h0064_8000, 32'h0064_7FFF, 32'h0000_0000);
        checkOutput("latEdgeN",   32'(bus.out_valid), 32'd0);
        stepCycle();
        checkOutput("latEdgeN1",  32'(bus.out_valid), 32'd0);
        stepCycle();
        checkOutput("latEdgeN2",  32'(bus.out_valid), 32'd1);
        checkOutput("roundPixel", 32'(bus.out_pixel), 32'h0065_6400);
        drain();

        applyStimulus(32'hFFFF_0000, 32'h0100_0000, 32'h00FF_7FFF);
        repeat (2) stepCycle();
        checkOutput("clampMixed", 32'(bus.out_pixel), 32'h0000_FFFF);
        drain();

        applyStimulus(32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000);
        repeat (2) stepCycle();
        checkOutput("clampMaxPos", 32'(bus.out_pixel), 32'h00FF_0000);
        drain();

        applyStimulus(32'h8000_0000, 32'h00FF_8000, 32'h0000_7FFF);
        repeat (2) stepCycle();
        checkOutput("clampMinNeg", 32'(bus.out_pixel), 32'h0000_FF00);
        drain();

        // Backpressure: credits allow exactly FIFO_DEPTH acceptances.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        accepted      = 0;
        for (int i = 0; i < 10; i++) begin
            driveRandom();
            @(negedge clk);
            if (bus.in_ready) accepted++;
            @(posedge clk);
            #1;
        end
        checkOutput("bpAccepted", 32'(accepted),      32'(FIFO_DEPTH));
        checkOutput("bpInReady",  32'(bus.in_ready),  32'd0);
        checkOutput("bpOutValid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bpStillFull", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("bpCreditBack", 32'(bus.in_ready), 32'd1);
        runCycles(6, 100, 100, 1'b0);
        drain();

        // Framing from a fresh frame: 10 back-to-back pixels.
        pulseReset();
        runCycles(10, 100, 100, 1'b0);
        drain();
        checkOutput("frameCount", 32'(outIdx), 32'd10);

        // Full FIFO with read and write on the same edges.
        bus.out_ready = 1'b0;
        runCycles(6, 100, 0, 1'b0);
        runCycles(40, 100, 0, 1'b1);
        drain();

        runCycles(300, 70, 60, 1'b0);
        drain();

        // Reset mid-frame with three entries buffered.
        pulseReset();
        runCycles(5, 100, 100, 1'b0);
        bus.in_valid = 1'b0;
        waited = 0;
        while (outIdx < 5 && waited < 20) begin
            stepCycle();
            waited++;
        end
        checkOutput("midFiveOut", 32'(outIdx), 32'd5);
        bus.out_ready = 1'b0;
        runCycles(3, 100, 0, 1'b0);
        bus.in_valid = 1'b0;
        repeat (3) stepCycle();
        checkOutput("midBuffered", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstOutValid", 32'(bus.out_valid), 32'd0);
        checkOutput("midRstInReady",  32'(bus.in_ready),  32'd1);
        stepCycle();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        stepCycle();
        applyStimulus(32'h0012_3456, 32'h00AB_0000, 32'h0000_C000);
        stepCycle();
        stepCycle();
        checkOutput("midNextValid", 32'(bus.out_valid), 32'd1);
        checkOutput("midNextSof",   32'(bus.out_sof),   32'd1);
        drain();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
